ex_mem_stage: RTL and testbench

- Registered EX→MEM boundary placed directly downstream of the ALU.
- Captures the ALU result, the overflow flag and the EX-stage control bits into a 2-entry skid buffer, using valid/ready handshakes on both sides.
- Converts trapping arithmetic overflow into a precise exception record (Ov) and suppresses all side effects of the faulting instruction.
- Exports the youngest buffered write for operand forwarding back into EX.

---
 rtl/ex_mem_stage_if.sv | 48 ++++
 rtl/ex_mem_stage.sv | 106 ++++++++++
 tb/tb_ex_mem_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX->MEM boundary bus: EX-side request, MEM-side head entry and the forwarding tap.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic        in_overflow;
  logic        in_ov_check;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic        in_mem_re;
  logic        in_mem_we;
  logic [31:0] in_store_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic        out_wen;
  logic        out_mem_re;
  logic        out_mem_we;
  logic [4:0]  out_waddr;
  logic        out_exc;
  logic [4:0]  out_exccode;

  logic        fwd_valid;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_data;
  logic        fwd_is_load;

  modport slave (
    input  in_valid, in_pc, in_alu_result, in_overflow, in_ov_check, in_wen,
           in_waddr, in_mem_re, in_mem_we, in_store_data, out_ready,
    output in_ready, out_valid, out_pc, out_alu_result, out_store_data, out_wen,
           out_mem_re, out_mem_we, out_waddr, out_exc, out_exccode,
           fwd_valid, fwd_waddr, fwd_data, fwd_is_load
  );

  modport master (
    output in_valid, in_pc, in_alu_result, in_overflow, in_ov_check, in_wen,
           in_waddr, in_mem_re, in_mem_we, in_store_data, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_result, out_store_data, out_wen,
           out_mem_re, out_mem_we, out_waddr, out_exc, out_exccode,
           fwd_valid, fwd_waddr, fwd_data, fwd_is_load
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register as a 2-entry skid buffer with precise overflow traps
// and a forwarding tap on the youngest buffered entry.
module ex_mem_stage #(
  parameter logic [4:0] EXC_OV = 5'h0C
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        wen;
    logic        mem_re;
    logic        mem_we;
    logic [4:0]  waddr;
    logic        exc;
    logic [4:0]  exccode;
  } entry_t;

  entry_t     slot [2];
  entry_t     incoming;
  entry_t     head_entry;
  entry_t     young_entry;
  logic       head;
  logic       tail;
  logic [1:0] count;
  logic       kill;
  logic       push;
  logic       pop;
  logic       trap;

  assign trap = bus.in_ov_check & bus.in_overflow;

  // A trapping instruction keeps pc/result for the handler but loses all side effects.
  always_comb begin
    incoming            = '0;
    incoming.pc         = bus.in_pc;
    incoming.alu_result = bus.in_alu_result;
    incoming.store_data = bus.in_store_data;
    incoming.waddr      = bus.in_waddr;
    incoming.wen        = bus.in_wen & ~trap;
    incoming.mem_re     = bus.in_mem_re & ~trap;
    incoming.mem_we     = bus.in_mem_we & ~trap;
    incoming.exc        = trap;
    incoming.exccode    = trap ? EXC_OV : 5'h00;
  end

  assign bus.in_ready  = (count != 2'd2) | kill;
  assign bus.out_valid = (count != 2'd0);
  assign push = bus.in_valid & bus.in_ready & ~kill & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot[0] <= '0;
      slot[1] <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      kill    <= 1'b0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      kill  <= 1'b0;
    end else begin
      if (push) begin
        slot[tail] <= incoming;
        tail       <= ~tail;
        if (incoming.exc)
          kill <= 1'b1;
      end
      if (pop)
        head <= ~head;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_entry  = slot[head];
  assign young_entry = slot[~tail];

  assign bus.out_pc         = head_entry.pc;
  assign bus.out_alu_result = head_entry.alu_result;
  assign bus.out_store_data = head_entry.store_data;
  assign bus.out_wen        = head_entry.wen;
  assign bus.out_mem_re     = head_entry.mem_re;
  assign bus.out_mem_we     = head_entry.mem_we;
  assign bus.out_waddr      = head_entry.waddr;
  assign bus.out_exc        = head_entry.exc;
  assign bus.out_exccode    = head_entry.exccode;

  // The youngest entry stays visible even in the cycle it pops.
  assign bus.fwd_valid   = (count != 2'd0) & young_entry.wen;
  assign bus.fwd_waddr   = young_entry.waddr;
  assign bus.fwd_data    = young_entry.alu_result;
  assign bus.fwd_is_load = young_entry.mem_re;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: handshakes, backpressure, overflow kill,
// flush, forwarding and asynchronous reset.
module tb_ex_mem_stage;
  logic clk;
  logic reset;
  logic flush;
  int   vectors;
  int   miscompares;

  ex_mem_stage_if bus ();

  ex_mem_stage #(.EXC_OV(5'h0C)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] res,
                               input logic ovf, input logic ovchk, input logic wen,
                               input logic [4:0] waddr, input logic re, input logic we,
                               input logic [31:0] sd);
    bus.in_valid      = valid;
    bus.in_pc         = pc;
    bus.in_alu_result = res;
    bus.in_overflow   = ovf;
    bus.in_ov_check   = ovchk;
    bus.in_wen        = wen;
    bus.in_waddr      = waddr;
    bus.in_mem_re     = re;
    bus.in_mem_we     = we;
    bus.in_store_data = sd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("rst_out_pc", bus.out_pc, 32'h0);
    checkOutput("rst_out_alu", bus.out_alu_result, 32'h0);
    checkOutput("rst_fwd_valid", {31'h0, bus.fwd_valid}, 32'h0);
    checkOutput("rst_fwd_data", bus.fwd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    // Single push with MEM ready
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 32'h0040_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("single_out_valid", {31'h0, bus.out_valid}, 32'h1);
    checkOutput("single_out_pc", bus.out_pc, 32'h0040_0000);
    checkOutput("single_out_alu", bus.out_alu_result, 32'h1234_5678);
    checkOutput("single_out_wen", {31'h0, bus.out_wen}, 32'h1);
    checkOutput("single_out_waddr", {27'h0, bus.out_waddr}, 32'd8);
    checkOutput("single_fwd_valid", {31'h0, bus.fwd_valid}, 32'h1);
    checkOutput("single_fwd_waddr", {27'h0, bus.fwd_waddr}, 32'd8);
    checkOutput("single_fwd_data", bus.fwd_data, 32'h1234_5678);
    tick();
    checkOutput("single_drained", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("single_fwd_gone", {31'h0, bus.fwd_valid}, 32'h0);

    // Backpressure: third instruction must wait for space
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h0, 32'hA0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("bp_ready_after1", {31'h0, bus.in_ready}, 32'h1);
    applyStimulus(1'b1, 32'h4, 32'hA4, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("bp_ready_after2", {31'h0, bus.in_ready}, 32'h0);
    checkOutput("bp_head_pc0", bus.out_pc, 32'h0);
    applyStimulus(1'b1, 32'h8, 32'hA8, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("bp_still_full", {31'h0, bus.in_ready}, 32'h0);
    checkOutput("bp_head_stable", bus.out_pc, 32'h0);
    checkOutput("bp_fwd_youngest", bus.fwd_data, 32'hA4);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_head_pc4", bus.out_pc, 32'h4);
    checkOutput("bp_ready_again", {31'h0, bus.in_ready}, 32'h1);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("bp_head_pc8", bus.out_pc, 32'h8);
    checkOutput("bp_head_alu8", bus.out_alu_result, 32'hA8);
    tick();
    checkOutput("bp_drained", {31'h0, bus.out_valid}, 32'h0);

    // Unsigned add: overflow flag ignored
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h10, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("uns_out_exc", {31'h0, bus.out_exc}, 32'h0);
    checkOutput("uns_out_wen", {31'h0, bus.out_wen}, 32'h1);
    checkOutput("uns_out_alu", bus.out_alu_result, 32'h8000_0000);
    bus.out_ready = 1'b1;
    tick();

    // Forwarding a load that is stalled in the buffer
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h20, 32'h1000, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checkOutput("ld_fwd_valid", {31'h0, bus.fwd_valid}, 32'h1);
    checkOutput("ld_fwd_is_load", {31'h0, bus.fwd_is_load}, 32'h1);
    checkOutput("ld_fwd_waddr", {27'h0, bus.fwd_waddr}, 32'd4);
    checkOutput("ld_fwd_data", bus.fwd_data, 32'h1000);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("ld_drained_fwd", {31'h0, bus.fwd_valid}, 32'h0);

    // Overflow trap, then three younger inputs consumed and dropped
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h30, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 32'h5);
    tick();
    checkOutput("ov_out_exc", {31'h0, bus.out_exc}, 32'h1);
    checkOutput("ov_out_exccode", {27'h0, bus.out_exccode}, 32'h0C);
    checkOutput("ov_out_wen", {31'h0, bus.out_wen}, 32'h0);
    checkOutput("ov_out_mem_we", {31'h0, bus.out_mem_we}, 32'h0);
    checkOutput("ov_out_pc", bus.out_pc, 32'h30);
    checkOutput("ov_fwd_valid", {31'h0, bus.fwd_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h34 + 32'(4 * i), 32'h99, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("ov_kill_in_ready", {31'h0, bus.in_ready}, 32'h1);
    end
    bus.in_valid = 1'b0;
    checkOutput("ov_head_kept", bus.out_pc, 32'h30);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("ov_dropped_none_left", {31'h0, bus.out_valid}, 32'h0);
    tick();
    checkOutput("ov_dropped_still_empty", {31'h0, bus.out_valid}, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Flush with two entries buffered and kill set
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 32'h40, 32'h55, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h44, 32'h66, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("fl_kill_ready_full", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("fl_head_pc", bus.out_pc, 32'h40);
    applyStimulus(1'b1, 32'h48, 32'h77, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("fl_out_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("fl_fwd_valid", {31'h0, bus.fwd_valid}, 32'h0);
    applyStimulus(1'b1, 32'h4C, 32'h4C4C, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("fl_next_valid", {31'h0, bus.out_valid}, 32'h1);
    checkOutput("fl_next_pc", bus.out_pc, 32'h4C);

    // Fill to two entries, then assert reset asynchronously mid-cycle
    applyStimulus(1'b1, 32'h50, 32'h5050, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("ar_full", {31'h0, bus.in_ready}, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_out_valid", {31'h0, bus.out_valid}, 32'h0);
    checkOutput("ar_out_pc", bus.out_pc, 32'h0);
    checkOutput("ar_out_alu", bus.out_alu_result, 32'h0);
    checkOutput("ar_out_wen", {31'h0, bus.out_wen}, 32'h0);
    checkOutput("ar_fwd_valid", {31'h0, bus.fwd_valid}, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    checkOutput("ar_in_ready", {31'h0, bus.in_ready}, 32'h1);
    checkOutput("ar_still_empty", {31'h0, bus.out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
